// File: rtl/riscv_dmem.sv
// riscv_dmem: byte-addressable data memory with a fixed-latency req/valid handshake,
// RV32 load/store sizing, sign/zero extension and error responses.
module riscv_dmem #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 256,
   parameter int WAIT  = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req,
   input  logic            we,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   output logic            ready,
   output logic            valid,
   output logic [XLEN-1:0] rdata,
   output logic            err
);
   localparam int NB = XLEN / 8;
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = WAIT > 0 ? $clog2(WAIT + 1) : 1;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic we_q, err_q;
   logic [2:0] f3_q;
   logic [XLEN-1:0] addr_q, wdata_q;
   logic [XLEN-1:0] mem [DEPTH];
   logic a_we, bad, acc, commit;
   logic [2:0] a_f3;
   logic [XLEN-1:0] a_addr, a_wdata, sdata, word, ld;
   logic [NB-1:0] mask;
   logic [7:0] b;
   logic [15:0] h;
   // In IDLE the live inputs drive decode (zero-wait commit); afterwards the latched copy does.
   always_comb begin
      acc = req && state == S_IDLE && !rst;
      a_we = state == S_IDLE ? we : we_q;
      a_f3 = state == S_IDLE ? funct3 : f3_q;
      a_addr = state == S_IDLE ? addr : addr_q;
      a_wdata = state == S_IDLE ? wdata : wdata_q;
      bad = a_f3 == 3'b011 || a_f3[2:1] == 2'b11 || (a_we && a_f3[2])
         || (a_f3[1:0] == 2'b01 && a_addr[0]) || (a_f3 == 3'b010 && a_addr[1:0] != 2'b00)
         || a_addr[XLEN-1:2] >= (XLEN-2)'(DEPTH);
      commit = !rst && a_we && !bad && ((acc && WAIT == 0) || (state == S_WAIT && cnt == CW'(1)));
      mask = a_f3[1:0] == 2'b00 ? NB'(1) << a_addr[1:0]
           : a_f3[1:0] == 2'b01 ? NB'(3) << {a_addr[1], 1'b0} : '1;
      sdata = a_f3[1:0] == 2'b00 ? {NB{a_wdata[7:0]}}
            : a_f3[1:0] == 2'b01 ? {(NB/2){a_wdata[15:0]}} : a_wdata;
   end
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: state_n = acc ? ((bad || WAIT == 0) ? S_RESP : S_WAIT) : S_IDLE;
         S_WAIT: state_n = cnt == CW'(1) ? S_RESP : S_WAIT;
         default: state_n = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt <= '0;
      end else begin
         state <= state_n;
         if (acc) begin
            we_q <= we;
            f3_q <= funct3;
            addr_q <= addr;
            wdata_q <= wdata;
            err_q <= bad;
            cnt <= CW'(WAIT);
         end else if (state == S_WAIT) cnt <= cnt - 1'b1;
      end
   end
   always_ff @(posedge clk)
      for (int i = 0; i < NB; i++)
         if (commit && mask[i]) mem[a_addr[AW+1:2]][i*8 +: 8] <= sdata[i*8 +: 8];
   always_comb begin
      word = mem[addr_q[AW+1:2]];
      b = word[{addr_q[1:0], 3'b000} +: 8];
      h = word[{addr_q[1], 4'b0000} +: 16];
      ld = f3_q[1:0] == 2'b00 ? {{(XLEN-8){~f3_q[2] & b[7]}}, b}
         : f3_q[1:0] == 2'b01 ? {{(XLEN-16){~f3_q[2] & h[15]}}, h} : word;
      ready = state == S_IDLE;
      valid = state == S_RESP;
      err = valid && err_q;
      rdata = valid && !err_q && !we_q ? ld : '0;
   end
endmodule

// File: doc/riscv_dmem.md
RISCV_DMEM -- requirements
Module: riscv_dmem

Interface
REQ-001 Parameter XLEN, default 32, data and address width in bits.
REQ-002 Parameter DEPTH, default 256, memory size in XLEN-bit words.
REQ-003 Parameter WAIT, default 1, extra wait cycles before each response (0 allowed).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  1  request strobe from the load/store stage.
REQ-007 we  input  1  1 = store, 0 = load.
REQ-008 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 addr  input  XLEN  byte address.
REQ-010 wdata  input  XLEN  store data, right-aligned.
REQ-011 ready  output  1  block can accept a request this cycle.
REQ-012 valid  output  1  one-cycle response strobe.
REQ-013 rdata  output  XLEN  extended load data, feeds the memory-access stage memi input.
REQ-014 err  output  1  response is an error, qualified by valid.

Function
REQ-015 The block SHALL implement states IDLE, WAIT, RESP; ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted at a rising edge where req=1 and ready=1; req while ready=0 SHALL be ignored.
REQ-017 On accept, we, funct3, addr, wdata SHALL be latched; later input changes SHALL not affect the transaction.
REQ-018 On accept with WAIT=0 the next state SHALL be RESP; otherwise WAIT with a counter loaded to WAIT.
REQ-019 In WAIT the counter SHALL decrement each edge, moving to RESP at the edge where it is 1; RESP is entered exactly WAIT edges after the accept edge, valid visible in the following cycle.
REQ-020 RESP SHALL last exactly one cycle with valid=1, then return to IDLE (ready=1 on the next cycle).
REQ-021 Error conditions SHALL be: funct3 in {011,110,111}; store with funct3 in {100,101}; H/HU with addr[0]=1; W with addr[1:0]!=0; addr[XLEN-1:2] >= DEPTH.
REQ-022 An erroring request SHALL go to RESP on the accept edge regardless of WAIT, with err=1, rdata=0, and no memory write.
REQ-023 A store SHALL write only the addressed byte lanes (B: lane addr[1:0]; H: lanes addr[1]*2 and +1; W: all) from wdata low bits, at the edge entering RESP.
REQ-024 A store response SHALL give rdata=0, err=0.
REQ-025 A load SHALL select the lane(s) from addr[1:0] and sign-extend for B/H, zero-extend for BU/HU; W unchanged.
REQ-026 Load data SHALL reflect all stores committed at earlier edges (read-after-write through the block is coherent).
REQ-027 Outside RESP, valid, err and rdata SHALL be 0.
REQ-028 Little-endian byte order: lane 0 = bits 7:0.

Reset
REQ-029 With rst=1 at an edge, state SHALL become IDLE, counter 0, valid=0, err=0, rdata=0; ready=1 from the next cycle.
REQ-030 Reset mid-transaction SHALL abort it; a store not yet at its commit edge SHALL not be written, and no valid SHALL follow.
REQ-031 Memory contents SHALL not be cleared by reset.
REQ-032 A req sampled with rst=1 SHALL be ignored.

Verification
REQ-033 WAIT=1: SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> valid 1 edge after accept, rdata=0xDEADBEEF, err=0; ready low for 2 cycles per request.
REQ-034 After REQ-033: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-035 SB 0x11 wdata 0x55 then LW 0x10 -> 0xDEAD55EF; SH 0x12 wdata 0x1234 then LW 0x10 -> 0x123455EF.
REQ-036 LW 0x12, LH 0x11, SW addr 4*DEPTH, funct3=011 -> each valid on cycle after accept with err=1, rdata=0; memory at 0x10 unchanged.
REQ-037 WAIT=3: SW 0x20 0xA5A5A5A5, rst pulsed 2 cycles after accept -> no valid; LW 0x20 afterwards returns prior contents; req held high during WAIT not accepted.
REQ-038 WAIT=0: back-to-back LW requests held req=1 -> accepted every second cycle, valid alternating 1/0.
